// File: rtl/fifo_reader.sv
// fifo_reader
//   Drains a show-ahead FIFO into a two-entry output buffer and presents the
//   buffer head on a valid/ready stream. A single-cycle flush discards the
//   buffered words and everything left in the FIFO, and counts them as drops.
//
// Ports
//   rclk        read-domain clock, all registers update on its rising edge
//   rrst_n      synchronous active-low reset
//   rdata       FIFO show-ahead read data, valid whenever rempty=0
//   rempty      FIFO empty flag
//   rinc        FIFO pop strobe, consumes rdata on the edge where it is 1
//   m_data      downstream data (buffer head, registered)
//   m_valid     downstream data valid
//   m_ready     downstream ready
//   flush       single-cycle flush request
//   busy        high whenever the controller is not IDLE
//   rd_count    saturating count of words delivered downstream
//   drop_count  saturating count of words discarded by flush

module fifo_reader #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DW-1:0]    rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    head_q, head_d;
  logic [DW-1:0]    tail_q, tail_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             push;
  logic             pop;

  // Adds up to 3 to a counter and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // In FLUSH the FIFO is drained as fast as it can supply words; otherwise
  // words are only pulled while the buffer has room and no flush is pending.
  assign rinc = rrst_n && !rempty &&
                ((state_q == FLUSH) || ((buf_cnt_q < 2'd2) && !flush));

  assign m_valid    = (buf_cnt_q != 2'd0) && (state_q != FLUSH);
  assign push       = rinc && (state_q != FLUSH);
  // A handshake on the flush cycle is not a delivery; the head is dropped.
  assign pop        = m_valid && m_ready && !flush;

  assign m_data     = head_q;
  assign busy       = (state_q != IDLE);
  assign rd_count   = rd_count_q;
  assign drop_count = drop_count_q;

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    buf_cnt_d    = buf_cnt_q;
    rd_count_d   = rd_count_q;
    drop_count_d = drop_count_q;

    case (state_q)
      FLUSH: begin
        if (rinc) begin
          drop_count_d = sat_add(drop_count_q, 2'd1);
        end
        if (rempty) begin
          state_d = IDLE;
        end
      end

      IDLE, ACTIVE: begin
        if (flush) begin
          state_d      = FLUSH;
          buf_cnt_d    = 2'd0;
          drop_count_d = sat_add(drop_count_q, buf_cnt_q);
        end else begin
          if (pop) begin
            rd_count_d = sat_add(rd_count_q, 2'd1);
          end

          // push needs buf_cnt<2 and pop needs buf_cnt>0, so push+pop only
          // happens with a single word held: the new word becomes the head.
          if (push && pop) begin
            head_d = rdata;
          end else if (push) begin
            if (buf_cnt_q == 2'd0) begin
              head_d = rdata;
            end else begin
              tail_d = rdata;
            end
            buf_cnt_d = buf_cnt_q + 2'd1;
          end else if (pop) begin
            if (buf_cnt_q == 2'd2) begin
              head_d = tail_q;
            end
            buf_cnt_d = buf_cnt_q - 2'd1;
          end

          if (state_q == IDLE) begin
            if (!rempty) begin
              state_d = ACTIVE;
            end
          end else if (rempty && (buf_cnt_d == 2'd0)) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        buf_cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      buf_cnt_q    <= 2'd0;
      rd_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      buf_cnt_q    <= buf_cnt_d;
      rd_count_q   <= rd_count_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
//   Bench for fifo_reader. A main instance (default widths) is fed from an
//   array-backed FIFO model; every word written into the model is also pushed
//   onto an expected-data queue and popped whenever the DUT delivers a word.
//   A second instance with 4-bit counters is used to reach counter saturation
//   in a few dozen cycles.

module tb_fifo_reader;

  logic        rclk;
  logic        rrst_n;
  logic [31:0] rdata;
  logic        rempty;
  logic        rinc;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        flush;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] drop_count;

  logic        s_rst_n;
  logic [7:0]  s_rdata;
  logic        s_rempty;
  logic        s_rinc;
  logic [7:0]  s_m_data;
  logic        s_m_valid;
  logic        s_ready;
  logic        s_flush;
  logic        s_busy;
  logic [3:0]  s_rd_count;
  logic [3:0]  s_drop_count;

  int checks   = 0;
  int failures = 0;

  // Main FIFO model: written by the stimulus, popped on edges where rinc=1.
  logic [31:0] fifo_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [31:0] exp_q [$];

  // Saturation FIFO model: word value equals its index.
  int s_wr = 0;
  int s_rd = 0;

  assign rempty   = (rd_ptr == wr_ptr);
  assign rdata    = fifo_mem[rd_ptr[7:0]];
  assign s_rempty = (s_rd == s_wr);
  assign s_rdata  = 8'(s_rd);

  always @(posedge rclk) begin
    if (rinc) rd_ptr <= rd_ptr + 1;
    if (s_rinc) s_rd <= s_rd + 1;
  end

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  fifo_reader #(.DW(32), .CNT_W(16)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rdata      (rdata),
    .rempty     (rempty),
    .rinc       (rinc),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush      (flush),
    .busy       (busy),
    .rd_count   (rd_count),
    .drop_count (drop_count)
  );

  fifo_reader #(.DW(8), .CNT_W(4)) dut_sat (
    .rclk       (rclk),
    .rrst_n     (s_rst_n),
    .rdata      (s_rdata),
    .rempty     (s_rempty),
    .rinc       (s_rinc),
    .m_data     (s_m_data),
    .m_valid    (s_m_valid),
    .m_ready    (s_ready),
    .flush      (s_flush),
    .busy       (s_busy),
    .rd_count   (s_rd_count),
    .drop_count (s_drop_count)
  );

  typedef struct {
    logic        push_en;
    logic [31:0] push_val;
    logic        ready;
    logic        flush_in;
    logic        exp_rinc;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_busy;
    logic [15:0] exp_rd;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    fifo_mem[wr_ptr[7:0]] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // Scoreboard: a word is delivered on the coming edge when this holds.
  task automatic sbSample();
    logic [31:0] exp_word;
    if (rrst_n && m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_underflow: got word %0h, expected no delivery", m_data);
      end else begin
        exp_word = exp_q.pop_front();
        checkOutput("sb_data", m_data, exp_word);
      end
    end
  endtask

  task automatic toNeg();
    @(negedge rclk);
    sbSample();
  endtask

  task automatic toPos();
    @(posedge rclk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.push_en) pushWord(v.push_val);
    m_ready = v.ready;
    flush   = v.flush_in;
  endtask

  task automatic checkRow(input vec_t v, input int idx);
    checkOutput($sformatf("row%0d_rinc", idx), 32'(rinc), 32'(v.exp_rinc));
    checkOutput($sformatf("row%0d_valid", idx), 32'(m_valid), 32'(v.exp_valid));
    if (v.exp_valid) checkOutput($sformatf("row%0d_data", idx), m_data, v.exp_data);
    checkOutput($sformatf("row%0d_busy", idx), 32'(busy), 32'(v.exp_busy));
    checkOutput($sformatf("row%0d_rd", idx), 32'(rd_count), 32'(v.exp_rd));
    checkOutput($sformatf("row%0d_drop", idx), 32'(drop_count), 32'(v.exp_drop));
  endtask

  task automatic waitSatIdle(input string name);
    int n;
    n = 0;
    toNeg();
    while (!(!s_busy && s_rd == s_wr) && n < 60) begin
      toPos();
      toNeg();
      n++;
    end
    checkOutput(name, 32'(s_busy || (s_rd != s_wr)), 32'd0);
    toPos();
  endtask

  task automatic pulseSatFlush();
    s_flush = 1'b1;
    toNeg();
    toPos();
    s_flush = 1'b0;
  endtask

  // Hard stop in case a wait is ever left unbounded by mistake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic [7:0] base;

    // {push_en, push_val, ready, flush, rinc, valid, data, busy, rd, drop}
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_00A0, 1'b1, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_00A0, 1'b1, 16'd0, 16'd0};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_00A0, 1'b1, 16'd0, 16'd0};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_00A0, 1'b1, 16'd0, 16'd0};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE_00A1, 1'b1, 16'd1, 16'd0};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE_00A2, 1'b1, 16'd2, 16'd0};
    vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_00A3, 1'b1, 16'd3, 16'd0};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_00A3, 1'b1, 16'd3, 16'd0};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 16'd4, 16'd0};
    vecs[10] = '{1'b1, 32'hCAFE_00A4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 16'd4, 16'd0};
    vecs[11] = '{1'b1, 32'hCAFE_00A5, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_00A4, 1'b1, 16'd4, 16'd0};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd4, 16'd1};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 16'd4, 16'd2};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 16'd4, 16'd2};

    rrst_n  = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    s_rst_n = 1'b0;
    s_ready = 1'b0;
    s_flush = 1'b0;

    // Reset state
    toPos();
    toNeg();
    checkOutput("rst_rinc", 32'(rinc), 32'd0);
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_data", m_data, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd", 32'(rd_count), 32'd0);
    checkOutput("rst_drop", 32'(drop_count), 32'd0);
    toPos();
    rrst_n = 1'b1;

    // Back-pressure, ordered drain, then flush colliding with a handshake
    for (int i = 0; i < 4; i++) pushWord(32'hCAFE_00A0 + 32'(i));
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      toNeg();
      checkRow(vecs[i], i);
      toPos();
    end
    checkOutput("table_sb_drained", 32'(exp_q.size()), 32'd2);
    exp_q.delete();

    // Streaming: one-cycle latency then one word per cycle
    m_ready = 1'b1;
    flush   = 1'b0;
    for (int i = 0; i < 4; i++) pushWord(32'h0000_00A0 + 32'(i));
    toNeg();
    checkOutput("lat_not_yet_valid", 32'(m_valid), 32'd0);
    toPos();
    for (int i = 0; i < 4; i++) begin
      toNeg();
      checkOutput($sformatf("stream_valid%0d", i), 32'(m_valid), 32'd1);
      toPos();
    end
    toNeg();
    checkOutput("stream_idle", 32'(busy), 32'd0);
    checkOutput("stream_rd", 32'(rd_count), 32'd8);
    checkOutput("stream_sb_empty", 32'(exp_q.size()), 32'd0);
    toPos();

    // Flush with a full buffer and five words still in the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) pushWord(32'h0000_00B0 + 32'(i));
    toNeg();
    toPos();
    toNeg();
    toPos();
    toNeg();
    checkOutput("full_rinc", 32'(rinc), 32'd0);
    checkOutput("full_head", m_data, 32'h0000_00B0);
    toPos();
    flush = 1'b1;
    toNeg();
    toPos();
    flush = 1'b0;
    toNeg();
    checkOutput("flush_valid", 32'(m_valid), 32'd0);
    checkOutput("flush_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 20) begin
      toPos();
      toNeg();
      n++;
    end
    checkOutput("flush_to_idle", 32'(busy), 32'd0);
    checkOutput("flush_drop", 32'(drop_count), 32'd9);
    checkOutput("flush_rd", 32'(rd_count), 32'd8);
    checkOutput("flush_fifo_drained", 32'(wr_ptr - rd_ptr), 32'd0);
    toPos();
    exp_q.delete();

    // Reset mid-stream: buffered word lost, reads resume right after
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) pushWord(32'h0000_00C0 + 32'(i));
    toNeg();
    toPos();
    toNeg();
    toPos();
    rrst_n = 1'b0;
    toNeg();
    checkOutput("midrst_rinc", 32'(rinc), 32'd0);
    toPos();
    checkOutput("midrst_valid", 32'(m_valid), 32'd0);
    checkOutput("midrst_data", m_data, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rd", 32'(rd_count), 32'd0);
    checkOutput("midrst_drop", 32'(drop_count), 32'd0);
    rrst_n = 1'b1;
    exp_q.delete();
    for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(fifo_mem[i[7:0]]);
    toNeg();
    checkOutput("resume_rinc", 32'(rinc), 32'd1);
    n = 0;
    while (!(!busy && rd_ptr == wr_ptr) && n < 30) begin
      toPos();
      toNeg();
      n++;
    end
    checkOutput("resume_idle", 32'(busy || (rd_ptr != wr_ptr)), 32'd0);
    checkOutput("resume_rd", 32'(rd_count), 32'd4);
    checkOutput("resume_drop", 32'(drop_count), 32'd0);
    checkOutput("resume_sb_empty", 32'(exp_q.size()), 32'd0);
    toPos();

    // Saturation on the narrow-counter instance
    s_rst_n = 1'b1;
    s_ready = 1'b0;
    s_wr = s_wr + 14;
    for (int i = 0; i < 3; i++) begin
      toNeg();
      toPos();
    end
    pulseSatFlush();
    waitSatIdle("sat_flush1_idle");
    checkOutput("sat_drop14", 32'(s_drop_count), 32'd14);

    s_wr = s_wr + 2;
    for (int i = 0; i < 3; i++) begin
      toNeg();
      toPos();
    end
    pulseSatFlush();
    waitSatIdle("sat_flush2_idle");
    checkOutput("sat_drop_clamp", 32'(s_drop_count), 32'd15);
    checkOutput("sat_valid_after_flush", 32'(s_m_valid), 32'd0);

    s_ready = 1'b1;
    base = 8'(s_wr);
    s_wr = s_wr + 14;
    n = 0;
    toNeg();
    while (!s_m_valid && n < 10) begin
      toPos();
      toNeg();
      n++;
    end
    checkOutput("sat_first_valid", 32'(s_m_valid), 32'd1);
    checkOutput("sat_first_data", 32'(s_m_data), 32'(base));
    toPos();
    waitSatIdle("sat_burst1_idle");
    checkOutput("sat_rd14", 32'(s_rd_count), 32'd14);

    s_wr = s_wr + 3;
    waitSatIdle("sat_burst2_idle");
    checkOutput("sat_rd_clamp", 32'(s_rd_count), 32'd15);
    checkOutput("sat_drop_hold", 32'(s_drop_count), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DW, default 32, data word width.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 rclk  input  1  read-domain clock; every register updates on its rising edge.
REQ-004 rrst_n  input  1  synchronous, active-low reset, sampled on the rising edge of rclk.
REQ-005 rdata  input  DW  FIFO read data; show-ahead, valid whenever rempty=0.
REQ-006 rempty  input  1  FIFO empty flag.
REQ-007 rinc  output  1  FIFO pop strobe; the current rdata is consumed on the rclk edge where rinc=1.
REQ-008 m_data  output  DW  downstream data.
REQ-009 m_valid  output  1  downstream data valid.
REQ-010 m_ready  input  1  downstream ready.
REQ-011 flush  input  1  single-cycle flush request.
REQ-012 busy  output  1  high when state != IDLE.
REQ-013 rd_count  output  CNT_W  number of words delivered downstream.
REQ-014 drop_count  output  CNT_W  number of words discarded by flush.

Function
REQ-015 The block SHALL contain a 2-entry output buffer, with occupancy buf_cnt in the range 0..2.
REQ-016 rinc SHALL be combinational: rrst_n and !rempty and ((state==FLUSH) or (state!=FLUSH and buf_cnt<2 and !flush)).
REQ-017 In IDLE/ACTIVE, on an edge with rinc=1 the buffer SHALL capture rdata at its tail.
REQ-018 m_valid SHALL equal (buf_cnt!=0 and state!=FLUSH).
REQ-019 m_data SHALL be the buffer head, driven from a register with no combinational path from rdata.
REQ-020 Latency: a word present on rdata with rempty=0 and buf_cnt=0 at edge N SHALL appear on m_data with m_valid=1 after edge N, i.e. one cycle.
REQ-021 A transfer SHALL occur on an edge with m_valid and m_ready both 1; the head pops and rd_count increments by 1.
REQ-022 A simultaneous push and pop SHALL leave buf_cnt unchanged and preserve word order.
REQ-023 While m_valid=1 and m_ready=0, m_data SHALL remain stable.
REQ-024 With buf_cnt=2, rinc SHALL be 0 even when m_ready=1.
REQ-025 With m_ready held at 1 and the FIFO never empty, throughput SHALL be 1 word/cycle after the first word.
REQ-026 FSM states SHALL be IDLE, ACTIVE and FLUSH.
REQ-027 IDLE->ACTIVE SHALL occur when rempty=0.
REQ-028 ACTIVE->IDLE SHALL occur when rempty=1 and buf_cnt is 0 after the current edge.
REQ-029 flush sampled 1 in IDLE or ACTIVE SHALL cause ->FLUSH and set buf_cnt to 0; buffered words are added to drop_count.
REQ-030 In FLUSH, each edge with rinc=1 SHALL increment drop_count by 1; no data is captured.
REQ-031 FLUSH->IDLE SHALL occur on the first edge in FLUSH at which rempty=1.
REQ-032 flush asserted while in FLUSH SHALL be ignored.
REQ-033 On the flush cycle itself, any m_valid and m_ready handshake SHALL NOT count and SHALL NOT pop; the head is dropped.
REQ-034 rd_count and drop_count SHALL saturate at all-ones; they never wrap.
REQ-035 A drop_count increment larger than 1, from buffered words, SHALL also saturate.

Reset
REQ-036 While rrst_n=0 at an edge: state=IDLE, buf_cnt=0, m_valid=0, m_data=0, rd_count=0, drop_count=0, busy=0.
REQ-037 rinc SHALL be 0 whenever rrst_n=0, independent of rempty.
REQ-038 Reset SHALL take priority over flush and over any handshake in the same cycle.
REQ-039 Reset mid-burst SHALL discard buffered words without counting them as drops.

Verification
REQ-040 Scenario: FIFO holds 0xA0..0xA3 and m_ready=1 -> m_data sequence A0, A1, A2, A3 on consecutive cycles, first word 1 cycle after rempty falls; rd_count=4; state returns to IDLE.
REQ-041 Scenario: 4 words present and m_ready=0 -> after 2 pops rinc=0 and buf_cnt=2; m_data holds A0; on m_ready=1 the order is A0..A3 with no loss.
REQ-042 Scenario: buf_cnt=2, 5 words left in the FIFO, flush pulse -> m_valid=0 next cycle; drop_count=7; state IDLE once rempty=1; rd_count unchanged.
REQ-043 Scenario: flush and m_valid and m_ready in the same cycle -> no rd_count increment; the head is counted in drop_count.
REQ-044 Scenario: preload rd_count to 0xFFFE, then deliver 3 words -> rd_count=0xFFFF; no wrap.
REQ-045 Scenario: rrst_n=0 asserted mid-stream with rempty=0 -> rinc=0 that cycle; all outputs 0 after the edge; normal reads resume on the first cycle with rrst_n=1.
